// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions
// inside the {a..g,dp} output byte and the hex-to-segment table.
package seg7_pkg;

   localparam int SEG_A  = 7;
   localparam int SEG_B  = 6;
   localparam int SEG_C  = 5;
   localparam int SEG_D  = 4;
   localparam int SEG_E  = 3;
   localparam int SEG_F  = 2;
   localparam int SEG_G  = 1;
   localparam int SEG_DP = 0;

   localparam logic [7:0] SEG_BLANK = 8'h00;

   // Entry n holds segments a..g (a in bit 6) for hex digit n.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b0001101, 7'b0111101, 7'b1001111, 7'b1000111
   };

endpackage

// File: rtl/seg7_hex_lut.sv
// Combinational hex digit to a..g segment lookup (a in bit 6, g in bit 0).
module seg7_hex_lut
   import seg7_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] segs
);

   assign segs = HEX_SEG[hex];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: double-buffered digits, per-digit enable,
// decimal points, leading-zero suppression and a blank interval per slot.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int NDIGITS      = 4,
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 16,
   parameter int SEG_ACT_LOW  = 0,
   parameter int DIG_ACT_LOW  = 0
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic                   load,
   input  logic [4*NDIGITS-1:0]   value,
   input  logic [NDIGITS-1:0]     dp,
   input  logic [NDIGITS-1:0]     en,
   input  logic                   lzs,
   output logic [7:0]             seg,
   output logic [NDIGITS-1:0]     dig,
   output logic                   frame_done,
   output logic                   pending
);

   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
   localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NDIGITS - 1);
   localparam logic [PW-1:0] LAST_PRE = PW'(CLK_DIV - 1);
   // XOR masks that map the internal active-high levels onto the pins.
   localparam logic [7:0]         SEG_POL = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
   localparam logic [NDIGITS-1:0] DIG_POL = (DIG_ACT_LOW != 0) ? '1 : '0;

   logic [PW-1:0]          prescaler;
   logic [IW-1:0]          idx;
   logic [4*NDIGITS-1:0]   pend_value, act_value;
   logic [NDIGITS-1:0]     pend_dp, act_dp, pend_en, act_en;
   logic                   tick, frame_end;

   logic [NDIGITS:0]       zero_from;
   logic [3:0]             cur_hex;
   logic                   cur_dp, cur_en, cur_dark;
   logic [6:0]             lut_segs;
   logic [7:0]             seg_next;
   logic [NDIGITS-1:0]     dig_next;

   assign tick      = (prescaler == LAST_PRE);
   assign frame_end = tick && (idx == LAST_IDX);

   seg7_hex_lut u_lut (
      .hex  (cur_hex),
      .segs (lut_segs)
   );

   // zero_from[i] is set when digit i and every digit above it are zero.
   always_comb begin
      zero_from = '0;
      zero_from[NDIGITS] = 1'b1;
      for (int i = NDIGITS - 1; i >= 0; i--) begin
         zero_from[i] = zero_from[i+1] & (act_value[4*i +: 4] == 4'h0);
      end
   end

   always_comb begin
      cur_hex  = 4'h0;
      cur_dp   = 1'b0;
      cur_en   = 1'b0;
      cur_dark = 1'b0;
      dig_next = '0;
      for (int i = 0; i < NDIGITS; i++) begin
         if (idx == IW'(i)) begin
            cur_hex     = act_value[4*i +: 4];
            cur_dp      = act_dp[i];
            cur_en      = act_en[i];
            cur_dark    = lzs && (i != 0) && zero_from[i];
            dig_next[i] = 1'b1;
         end
      end
      if (int'(prescaler) < BLANK_CYCLES) dig_next = '0;
   end

   // A suppressed digit keeps its decimal point; a disabled digit is fully dark.
   always_comb begin
      seg_next = SEG_BLANK;
      if (cur_en) begin
         seg_next[SEG_DP] = cur_dp;
         if (!cur_dark) seg_next[SEG_A:SEG_G] = lut_segs;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         prescaler  <= '0;
         idx        <= '0;
         pend_value <= '0;
         pend_dp    <= '0;
         pend_en    <= '0;
         act_value  <= '0;
         act_dp     <= '0;
         act_en     <= '0;
         pending    <= 1'b0;
         frame_done <= 1'b0;
         seg        <= SEG_POL;
         dig        <= DIG_POL;
      end else begin
         prescaler  <= tick ? '0 : prescaler + 1'b1;
         if (tick) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
         frame_done <= frame_end;
         // Active takes the old pending contents even if a load lands this cycle.
         if (frame_end && pending) begin
            act_value <= pend_value;
            act_dp    <= pend_dp;
            act_en    <= pend_en;
         end
         if (load) begin
            pend_value <= value;
            pend_dp    <= dp;
            pend_en    <= en;
            pending    <= 1'b1;
         end else if (frame_end) begin
            pending    <= 1'b0;
         end
         seg <= seg_next ^ SEG_POL;
         dig <= dig_next ^ DIG_POL;
      end
   end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a scoreboard of expected {dig,seg} per slot,
// plus an inverted-polarity instance for pin-level checks.
module tb_seg7_scan_driver;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        load = 1'b0, load_n = 1'b0;
   logic [15:0] value = '0, value_n = '0;
   logic [3:0]  dp = '0, dp_n = '0;
   logic [3:0]  en = '0, en_n = '0;
   logic        lzs = 1'b0;
   logic [7:0]  seg, seg_n;
   logic [3:0]  dig, dig_n;
   logic        frame_done, frame_done_n;
   logic        pending, pending_n;

   int total = 0;
   int bad = 0;
   logic [11:0] exp_q[$];
   logic [3:0]  prev_dig = '0;

   always #5 clock = ~clock;

   seg7_scan_driver #(.NDIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1),
                      .SEG_ACT_LOW(0), .DIG_ACT_LOW(0)) dut (
      .clock(clock), .reset_n(reset_n), .load(load), .value(value),
      .dp(dp), .en(en), .lzs(lzs), .seg(seg), .dig(dig),
      .frame_done(frame_done), .pending(pending));

   seg7_scan_driver #(.NDIGITS(4), .CLK_DIV(4), .BLANK_CYCLES(1),
                      .SEG_ACT_LOW(1), .DIG_ACT_LOW(1)) dut_n (
      .clock(clock), .reset_n(reset_n), .load(load_n), .value(value_n),
      .dp(dp_n), .en(en_n), .lzs(1'b0), .seg(seg_n), .dig(dig_n),
      .frame_done(frame_done_n), .pending(pending_n));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: the first non-blank cycle of each slot is one output event.
   always @(negedge clock) begin
      if (dig != 4'h0 && prev_dig == 4'h0 && exp_q.size() > 0) begin
         logic [11:0] e;
         e = exp_q.pop_front();
         total++;
         if ({dig, seg} !== e) begin
            bad++;
            $display("FAIL slot: got dig=%b seg=%h expected dig=%b seg=%h",
                     dig, seg, e[11:8], e[7:0]);
         end
      end
      prev_dig <= dig;
   end

   task automatic wait_frame();
      int n = 0;
      do begin
         @(negedge clock);
         n++;
      end while (!frame_done && n < 64);
      if (!frame_done) chk("frame_timeout", 32'd0, 32'd1);
   endtask

   // Queue one frame of expectations (digit0 first) and wait for it to drain.
   task automatic push_frame(input logic [7:0] s0, input logic [7:0] s1,
                             input logic [7:0] s2, input logic [7:0] s3);
      int n = 0;
      exp_q.push_back({4'b0001, s0});
      exp_q.push_back({4'b0010, s1});
      exp_q.push_back({4'b0100, s2});
      exp_q.push_back({4'b1000, s3});
      while (exp_q.size() > 0 && n < 64) begin
         @(negedge clock);
         n++;
      end
      if (exp_q.size() > 0) begin
         chk("drain_timeout", exp_q.size(), 32'd0);
         exp_q.delete();
      end
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] e);
      value = v;
      dp    = d;
      en    = e;
      load  = 1'b1;
      @(negedge clock);
      load  = 1'b0;
   endtask

   initial begin
      int cyc, blanks;
      // Reset state on both polarities.
      #12;
      chk("rst_seg", seg, 8'h00);
      chk("rst_dig", dig, 4'h0);
      chk("rst_pending", pending, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_seg_n", seg_n, 8'hFF);
      chk("rst_dig_n", dig_n, 4'hF);
      @(negedge clock);
      reset_n = 1'b1;
      value_n = 16'h8888; dp_n = 4'hF; en_n = 4'hF; load_n = 1'b1;
      @(negedge clock);
      load_n = 1'b0;

      // Idle frame: period, blank count and dark segments.
      wait_frame();
      cyc = 0; blanks = 0;
      do begin
         @(negedge clock);
         cyc++;
         if (dig == 4'h0) blanks++;
      end while (!frame_done && cyc < 64);
      chk("frame_period", cyc, 16);
      chk("blank_cycles", blanks, 4);
      push_frame(8'h00, 8'h00, 8'h00, 8'h00);

      // Inverted instance: 8 with dp shows seg=00, active digit pulled low.
      wait_frame();
      @(negedge clock);
      chk("inv_blank_dig", dig_n, 4'hF);
      chk("inv_blank_seg", seg_n, 8'h00);
      @(negedge clock);
      chk("inv_dig", dig_n, 4'b1110);
      chk("inv_seg", seg_n, 8'h00);

      // Basic decode with one decimal point.
      do_load(16'h12AF, 4'b0100, 4'hF);
      chk("pending_set", pending, 1'b1);
      wait_frame();
      chk("pending_clr", pending, 1'b0);
      push_frame(8'h8E, 8'hEE, 8'hDB, 8'h60);

      // Leading-zero suppression, including a dark digit with its dp lit.
      lzs = 1'b1;
      do_load(16'h0030, 4'b0000, 4'hF);
      wait_frame();
      push_frame(8'hFC, 8'hF2, 8'h00, 8'h00);
      do_load(16'h0000, 4'b0000, 4'hF);
      wait_frame();
      push_frame(8'hFC, 8'h00, 8'h00, 8'h00);
      do_load(16'h0030, 4'b1000, 4'hF);
      wait_frame();
      push_frame(8'hFC, 8'hF2, 8'h00, 8'h01);
      lzs = 1'b0;

      // Disabled digit hides its dp too.
      do_load(16'h8888, 4'hF, 4'b1110);
      wait_frame();
      push_frame(8'h00, 8'hFF, 8'hFF, 8'hFF);

      // Two loads in one frame: last write wins.
      wait_frame();
      repeat (2) @(negedge clock);
      do_load(16'h1111, 4'h0, 4'hF);
      @(negedge clock);
      do_load(16'h2222, 4'h0, 4'hF);
      wait_frame();
      push_frame(8'hDA, 8'hDA, 8'hDA, 8'hDA);

      // Load on the exact boundary cycle, with older data already pending.
      wait_frame();
      repeat (2) @(negedge clock);
      do_load(16'h3333, 4'h0, 4'hF);
      repeat (12) @(negedge clock);
      do_load(16'h4444, 4'h0, 4'hF);
      chk("bnd_frame_done", frame_done, 1'b1);
      chk("bnd_pending", pending, 1'b1);
      push_frame(8'hF2, 8'hF2, 8'hF2, 8'hF2);
      wait_frame();
      chk("bnd_pending_clr", pending, 1'b0);
      push_frame(8'h66, 8'h66, 8'h66, 8'h66);

      // Mid-slot reset with data pending.
      do_load(16'h5555, 4'hF, 4'hF);
      repeat (2) @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("mid_rst_seg", seg, 8'h00);
      chk("mid_rst_dig", dig, 4'h0);
      chk("mid_rst_pending", pending, 1'b0);
      chk("mid_rst_seg_n", seg_n, 8'hFF);
      chk("mid_rst_dig_n", dig_n, 4'hF);
      @(negedge clock);
      reset_n = 1'b1;
      push_frame(8'h00, 8'h00, 8'h00, 8'h00);
      chk("post_rst_pending", pending, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
